// File: rtl/cpu_csr_pkg.sv
// cpu_csr_pkg
// Shared CSR constants for the hardware performance monitor block:
// base addresses of each counter CSR family, the mhpmevent field
// layout, and the index of the first programmable hpmcounter.
package cpu_csr_pkg;

  // Base addresses. Counter i lives at base + i.
  localparam logic [11:0] ADDR_MHPMCOUNTER   = 12'hB03;
  localparam logic [11:0] ADDR_MHPMCOUNTERH  = 12'hB83;
  localparam logic [11:0] ADDR_HPMCOUNTER    = 12'hC03;
  localparam logic [11:0] ADDR_HPMCOUNTERH   = 12'hC83;
  localparam logic [11:0] ADDR_MHPMEVENT     = 12'h323;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

  // mhpmevent layout: event select in the low bits, sticky overflow on top.
  localparam int SEL_W  = 5;
  localparam int OF_BIT = 31;

  // Counter 0 corresponds to hpmcounter3, so inhibit bits start at 3.
  localparam int HPM_FIRST = 3;

endpackage

// File: rtl/cpu_hpm_counter.sv
// cpu_hpm_counter
// One programmable performance counter slice: CNT_WIDTH-bit counter,
// event select register and sticky overflow flag.
//
// Ports:
//   clk, rst     clock / asynchronous active-high reset
//   events       event pulse bus shared by all slices
//   inhibit      this counter's mcountinhibit bit
//   wr_lo/wr_hi  CSR write strobes for the low / high counter halves
//   wr_evt       CSR write strobe for this slice's mhpmevent
//   data_in      CSR write data
//   count        current counter value
//   sel          current event select
//   of           sticky overflow flag
module cpu_hpm_counter
  import cpu_csr_pkg::*;
#(
  parameter int NUM_EVENTS = 16,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  inhibit,
  input  logic                  wr_lo,
  input  logic                  wr_hi,
  input  logic                  wr_evt,
  input  logic [31:0]           data_in,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [SEL_W-1:0]      sel,
  output logic                  of
);

  logic [31:0] ev_ext;
  logic        selected;
  logic        bump;
  logic        wrap;

  // Zero-extending to 32 makes every select above NUM_EVENTS hit a 0 bit.
  assign ev_ext   = 32'(events);
  assign selected = (sel != '0) && ev_ext[sel - 5'd1];

  // A software write to either half takes priority and swallows the increment.
  assign bump = selected && !inhibit && !wr_lo && !wr_hi;
  assign wrap = bump && (&count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wr_lo) begin
      count[31:0] <= data_in;
    end else if (wr_hi) begin
      count[CNT_WIDTH-1:32] <= data_in[CNT_WIDTH-33:0];
    end else if (bump) begin
      count <= count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // A hardware overflow always sets OF, even against a software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '0;
      of  <= 1'b0;
    end else if (wr_evt) begin
      sel <= data_in[SEL_W-1:0];
      of  <= data_in[OF_BIT] | wrap;
    end else begin
      of  <= of | wrap;
    end
  end

endmodule

// File: rtl/cpu_hpm_counters.sv
// cpu_hpm_counters
// Bank of NUM_COUNTERS RISC-V style hardware performance counters
// (mhpmcounter3.. / mhpmevent3..) with mcountinhibit and an overflow
// interrupt. The top holds CSR address decode, the inhibit register
// and the combinational read mux; each counter is a cpu_hpm_counter.
//
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   addr       CSR address
//   data_in    CSR write data
//   wr         CSR write strobe
//   data_out   CSR read data (combinational)
//   events     event pulse bus
//   ovf_irq    OR of all sticky overflow flags
module cpu_hpm_counters
  import cpu_csr_pkg::*;
#(
  parameter int NUM_COUNTERS = 4,
  parameter int NUM_EVENTS   = 16,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           addr,
  input  logic [31:0]           data_in,
  input  logic                  wr,
  output logic [31:0]           data_out,
  input  logic [NUM_EVENTS-1:0] events,
  output logic                  ovf_irq
);

  logic [NUM_COUNTERS-1:0] inhibit;
  logic [NUM_COUNTERS-1:0] wr_lo;
  logic [NUM_COUNTERS-1:0] wr_hi;
  logic [NUM_COUNTERS-1:0] wr_evt;
  logic [NUM_COUNTERS-1:0] of_vec;
  logic [CNT_WIDTH-1:0]    cnt     [NUM_COUNTERS];
  logic [63:0]             cnt_ext [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel_arr [NUM_COUNTERS];

  logic wr_inhibit;
  assign wr_inhibit = wr && (addr == ADDR_MCOUNTINHIBIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inhibit <= '0;
    end else if (wr_inhibit) begin
      inhibit <= data_in[HPM_FIRST +: NUM_COUNTERS];
    end
  end

  // Only the mhpm* addresses decode as writes; hpm* aliases are read-only.
  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    assign wr_lo[i]   = wr && (addr == ADDR_MHPMCOUNTER  + 12'(i));
    assign wr_hi[i]   = wr && (addr == ADDR_MHPMCOUNTERH + 12'(i));
    assign wr_evt[i]  = wr && (addr == ADDR_MHPMEVENT    + 12'(i));
    assign cnt_ext[i] = 64'(cnt[i]);

    cpu_hpm_counter #(
      .NUM_EVENTS (NUM_EVENTS),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_counter (
      .clk     (clk),
      .rst     (rst),
      .events  (events),
      .inhibit (inhibit[i]),
      .wr_lo   (wr_lo[i]),
      .wr_hi   (wr_hi[i]),
      .wr_evt  (wr_evt[i]),
      .data_in (data_in),
      .count   (cnt[i]),
      .sel     (sel_arr[i]),
      .of      (of_vec[i])
    );
  end

  // Addresses are disjoint, so at most one branch below matches.
  always_comb begin
    data_out = '0;
    if (addr == ADDR_MCOUNTINHIBIT) begin
      data_out = 32'(inhibit) << HPM_FIRST;
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (addr == ADDR_MHPMCOUNTER + 12'(i) || addr == ADDR_HPMCOUNTER + 12'(i)) begin
        data_out = cnt_ext[i][31:0];
      end
      if (addr == ADDR_MHPMCOUNTERH + 12'(i) || addr == ADDR_HPMCOUNTERH + 12'(i)) begin
        data_out = cnt_ext[i][63:32];
      end
      if (addr == ADDR_MHPMEVENT + 12'(i)) begin
        data_out = {of_vec[i], {(OF_BIT-SEL_W){1'b0}}, sel_arr[i]};
      end
    end
  end

  assign ovf_irq = |of_vec;

endmodule

// File: tb/tb_cpu_hpm_counters.sv
// tb_cpu_hpm_counters
// Self-checking bench: directed scenarios followed by a randomized phase,
// all compared against a behavioural model of the counter bank.
module tb_cpu_hpm_counters;

  localparam int NC = 4;
  localparam int NE = 16;
  localparam int CW = 40;
  localparam longint unsigned MASK = (64'd1 << CW) - 64'd1;

  logic          clk;
  logic          rst;
  logic [11:0]   addr;
  logic [31:0]   data_in;
  logic          wr;
  logic [31:0]   data_out;
  logic [NE-1:0] events;
  logic          ovf_irq;

  cpu_hpm_counters #(
    .NUM_COUNTERS (NC),
    .NUM_EVENTS   (NE),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .data_out (data_out),
    .events   (events),
    .ovf_irq  (ovf_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  longint unsigned m_cnt [NC];
  int              m_sel [NC];
  bit              m_of  [NC];
  bit              m_inh [NC];

  int n_checks;
  int n_pass;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0;
      m_sel[i] = 0;
      m_of[i]  = 0;
      m_inh[i] = 0;
    end
  endtask

  task automatic model_step(input bit w, input logic [11:0] a, input logic [31:0] d,
                            input logic [NE-1:0] ev);
    bit inh_old [NC];
    for (int i = 0; i < NC; i++) inh_old[i] = m_inh[i];
    for (int i = 0; i < NC; i++) begin
      bit hit;
      bit wlo, whi, wev;
      hit = 0;
      if (m_sel[i] >= 1 && m_sel[i] <= NE) begin
        if (ev[m_sel[i]-1] && !inh_old[i]) hit = 1;
      end
      wlo = w && (a == 12'hB03 + 12'(i));
      whi = w && (a == 12'hB83 + 12'(i));
      wev = w && (a == 12'h323 + 12'(i));
      if (wev) begin
        m_sel[i] = int'(d[4:0]);
        m_of[i]  = d[31];
      end
      if (wlo) begin
        m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | longint'(d);
      end else if (whi) begin
        m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF) | ((longint'(d) << 32) & MASK);
      end else if (hit) begin
        if (m_cnt[i] == MASK) begin
          m_cnt[i] = 0;
          m_of[i]  = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    if (w && a == 12'h320) begin
      for (int i = 0; i < NC; i++) m_inh[i] = d[3+i];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a == 12'h320) begin
      for (int i = 0; i < NC; i++) r[3+i] = m_inh[i];
    end
    for (int i = 0; i < NC; i++) begin
      if (a == 12'hB03 + 12'(i) || a == 12'hC03 + 12'(i)) r = m_cnt[i][31:0];
      if (a == 12'hB83 + 12'(i) || a == 12'hC83 + 12'(i)) r = 32'(m_cnt[i] >> 32);
      if (a == 12'h323 + 12'(i)) r = {m_of[i], 26'h0, 5'(m_sel[i])};
    end
    return r;
  endfunction

  function automatic logic model_irq();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NC; i++) r = r | m_of[i];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle of stimulus; the model advances on the same edge.
  task automatic applyStimulus(input bit w, input logic [11:0] a, input logic [31:0] d,
                               input logic [NE-1:0] ev);
    @(negedge clk);
    wr      = w;
    addr    = a;
    data_in = d;
    events  = ev;
    @(posedge clk);
    if (!rst) model_step(w, a, d, ev);
    #1;
    wr     = 1'b0;
    events = '0;
  endtask

  task automatic readCheck(input string tag, input logic [11:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    checkOutput(tag, data_out, exp);
  endtask

  task automatic readModel(input string tag, input logic [11:0] a);
    readCheck(tag, a, model_read(a));
  endtask

  task automatic checkIrq(input string tag, input logic exp);
    checkOutput(tag, {31'h0, ovf_irq}, {31'h0, exp});
  endtask

  function automatic logic [11:0] pick_addr();
    logic [11:0] k;
    k = 12'($urandom_range(0, 4));
    case ($urandom_range(0, 9))
      0:       return 12'hB03 + k;
      1:       return 12'hB83 + k;
      2:       return 12'hC03 + k;
      3:       return 12'hC83 + k;
      4, 5, 9: return 12'h323 + k;
      6:       return 12'h320;
      7:       return 12'hB02;
      default: return 12'h000;
    endcase
  endfunction

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    wr       = 1'b0;
    addr     = '0;
    data_in  = '0;
    events   = '0;
    model_reset();

    // Reset state
    #2;
    checkIrq("rst_irq", 1'b0);
    readCheck("rst_b03", 12'hB03, 32'h0);
    readCheck("rst_323", 12'h323, 32'h0);
    readCheck("rst_320", 12'h320, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic counting and alias reads
    applyStimulus(1, 12'hB03, 32'h0, '0);
    applyStimulus(1, 12'h323, 32'h2, '0);
    readCheck("evt_sel2", 12'h323, 32'h2);
    applyStimulus(0, 12'h000, 32'h0, 16'h0002);
    readCheck("latency_1", 12'hC03, 32'd1);
    repeat (4) applyStimulus(0, 12'h000, 32'h0, 16'h0002);
    readCheck("cnt5_c03", 12'hC03, 32'd5);
    readCheck("cnt5_b03", 12'hB03, 32'd5);
    readCheck("cnt5_c83", 12'hC83, 32'h0);

    // Wrap and overflow
    applyStimulus(1, 12'hB03, 32'hFFFF_FFFF, '0);
    applyStimulus(1, 12'hB83, 32'hFFFF_FFFF, '0);
    readCheck("hi_mask40", 12'hB83, 32'h0000_00FF);
    applyStimulus(1, 12'h323, 32'h1, '0);
    applyStimulus(0, 12'h000, 32'h0, 16'h0001);
    readCheck("wrap_lo", 12'hC03, 32'h0);
    readCheck("wrap_hi", 12'hC83, 32'h0);
    readCheck("wrap_of", 12'h323, 32'h8000_0001);
    checkIrq("wrap_irq", 1'b1);
    applyStimulus(1, 12'h323, 32'h1, '0);
    checkIrq("clr_irq", 1'b0);

    // Hardware OF set beats a simultaneous software clear
    applyStimulus(1, 12'hB03, 32'hFFFF_FFFF, '0);
    applyStimulus(1, 12'hB83, 32'h0000_00FF, '0);
    applyStimulus(1, 12'h323, 32'h1, 16'h0001);
    readCheck("hwwin_of", 12'h323, 32'h8000_0001);
    readCheck("hwwin_lo", 12'hB03, 32'h0);
    checkIrq("hwwin_irq", 1'b1);

    // Write collides with increment
    applyStimulus(1, 12'hB03, 32'h100, 16'h0001);
    readCheck("coll_lo", 12'hB03, 32'h100);
    readCheck("coll_hi", 12'hB83, 32'h0);
    readCheck("coll_of", 12'h323, 32'h8000_0001);
    applyStimulus(1, 12'h323, 32'h1, '0);
    applyStimulus(1, 12'hB83, 32'hFF, '0);
    applyStimulus(1, 12'hB03, 32'hFFFF_FFFF, 16'h0001);
    readCheck("collwrap_lo", 12'hB03, 32'hFFFF_FFFF);
    readCheck("collwrap_hi", 12'hB83, 32'hFF);
    readCheck("collwrap_of", 12'h323, 32'h1);
    applyStimulus(1, 12'hB83, 32'h12, 16'h0001);
    readCheck("collhi_lo", 12'hB03, 32'hFFFF_FFFF);
    readCheck("collhi_hi", 12'hB83, 32'h12);

    // Inhibit
    applyStimulus(1, 12'hB03, 32'h0, '0);
    applyStimulus(1, 12'hB83, 32'h0, '0);
    applyStimulus(1, 12'h320, 32'hFFFF_FFFF, '0);
    readCheck("inh_mask", 12'h320, 32'h78);
    applyStimulus(1, 12'h320, 32'h8, '0);
    readCheck("inh_rd", 12'h320, 32'h8);
    repeat (10) applyStimulus(0, 12'h000, 32'h0, 16'h0001);
    readCheck("inh_hold", 12'hB03, 32'h0);
    applyStimulus(1, 12'h320, 32'h0, 16'h0001);
    readCheck("inh_clredge", 12'hB03, 32'h0);
    applyStimulus(0, 12'h000, 32'h0, 16'h0001);
    readCheck("inh_resume", 12'hB03, 32'h1);

    // Selects that count nothing
    applyStimulus(1, 12'h323, 32'h0, '0);
    repeat (3) applyStimulus(0, 12'h000, 32'h0, 16'hFFFF);
    readCheck("sel0", 12'hB03, 32'h1);
    applyStimulus(1, 12'h323, 32'h7FFF_FFFF, '0);
    readCheck("sel31_rd", 12'h323, 32'h1F);
    repeat (3) applyStimulus(0, 12'h000, 32'h0, 16'hFFFF);
    readCheck("sel31", 12'hB03, 32'h1);
    applyStimulus(1, 12'h323, 32'd17, '0);
    repeat (3) applyStimulus(0, 12'h000, 32'h0, 16'hFFFF);
    readCheck("sel17", 12'hB03, 32'h1);
    applyStimulus(1, 12'h323, 32'd16, '0);
    applyStimulus(0, 12'h000, 32'h0, 16'h8000);
    readCheck("sel16", 12'hB03, 32'h2);

    // Read-only aliases and unmapped addresses
    applyStimulus(1, 12'hC03, 32'h55, '0);
    readCheck("ro_c03", 12'hB03, 32'h2);
    applyStimulus(1, 12'hB07, 32'h55, '0);
    readCheck("unmap_b07", 12'hB07, 32'h0);
    applyStimulus(1, 12'h327, 32'h5, '0);
    readCheck("unmap_327", 12'h327, 32'h0);
    readCheck("unmap_c07", 12'hC07, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < NC; i++) begin
      applyStimulus(1, 12'h323 + 12'(i), 32'($urandom_range(1, NE)), '0);
    end
    for (int k = 0; k < 300; k++) begin
      bit w;
      w = ($urandom_range(0, 3) == 0);
      a = pick_addr();
      d = $urandom;
      if (a[11:8] == 4'h3 && a != 12'h320) d = {d[31], 26'h0, 5'($urandom_range(0, 20))};
      else if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF8 | {29'h0, d[2:0]};
      applyStimulus(w, a, d, NE'($urandom));
      checkIrq("rnd_irq", model_irq());
      if (k % 50 == 49) begin
        for (int j = 0; j < 5; j++) begin
          readModel("rnd_b03", 12'hB03 + 12'(j));
          readModel("rnd_b83", 12'hB83 + 12'(j));
          readModel("rnd_c03", 12'hC03 + 12'(j));
          readModel("rnd_c83", 12'hC83 + 12'(j));
          readModel("rnd_323", 12'h323 + 12'(j));
        end
        readModel("rnd_320", 12'h320);
        readModel("rnd_b02", 12'hB02);
      end
    end

    // Asynchronous reset mid-count
    applyStimulus(1, 12'h320, 32'h0, '0);
    for (int i = 0; i < NC; i++) begin
      applyStimulus(1, 12'hB03 + 12'(i), 32'hFFFF_FFFF, '0);
      applyStimulus(1, 12'hB83 + 12'(i), 32'hFF, '0);
      applyStimulus(1, 12'h323 + 12'(i), 32'(i + 1), '0);
    end
    repeat (3) applyStimulus(0, 12'h000, 32'h0, 16'h000F);
    readModel("pre_rst_b05", 12'hB05);
    checkIrq("pre_rst_irq", 1'b1);
    #3;
    rst = 1'b1;
    #1;
    checkIrq("arst_irq", 1'b0);
    model_reset();
    for (int i = 0; i < NC; i++) begin
      readCheck("arst_lo", 12'hB03 + 12'(i), 32'h0);
      readCheck("arst_evt", 12'h323 + 12'(i), 32'h0);
    end
    readCheck("arst_320", 12'h320, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 12'h000, 32'h0, 16'hFFFF);
    readModel("post_rst_b03", 12'hB03);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
